// File: rtl/aia_msi_pkg.sv
// Shared types for the MSI issue path: request record, file stride and issue FSM states.
package aia_msi_pkg;

   localparam int MSI_ADDR_W        = 64;
   localparam int MSI_DATA_W        = 64;
   localparam int IMSIC_FILE_STRIDE = 32'h1000;
   localparam int IMSIC_FILE_SHIFT  = $clog2(IMSIC_FILE_STRIDE);

   typedef struct packed {
      logic [MSI_ADDR_W-1:0] addr;
      logic [MSI_DATA_W-1:0] data;
   } msi_req_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GUARD,
      ST_WAIT
   } msi_state_e;

endpackage

// File: rtl/msi_req_fifo.sv
// Show-ahead synchronous FIFO of translated MSI requests; head is visible on rdata while not empty.
module msi_req_fifo
   import aia_msi_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  msi_req_t               wdata,
   input  logic                   pop,
   output msi_req_t               rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   msi_req_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imsic_msi_issue_queue.sv
// Queues MSI requests, translates them to seteipnum_le writes and issues them one at a time
// to the AXI-Lite write master, pacing on its busy flag.
module imsic_msi_issue_queue
   import aia_msi_pkg::*;
#(
   parameter int          AXI_ADDR_WIDTH = 64,
   parameter int          AXI_DATA_WIDTH = 64,
   parameter int          NR_SRC         = 30,
   parameter int          NR_INTP_FILES  = 2,
   parameter int          DEPTH          = 4,
   parameter logic [63:0] IMSIC_BASE     = 64'h2400_0000,
   parameter int          NR_SRC_LEN     = $clog2(NR_SRC),
   parameter int          FILE_LEN       = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_msi_valid,
   output logic                      o_msi_ready,
   input  logic [FILE_LEN-1:0]       i_msi_file,
   input  logic [NR_SRC_LEN-1:0]     i_msi_eiid,
   output logic                      o_wr_ready,
   output logic [AXI_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [AXI_DATA_WIDTH-1:0] o_wr_data,
   input  logic                      i_wr_busy,
   output logic                      o_msi_err,
   output logic [$clog2(DEPTH):0]    o_pending
);

   logic                      legal;
   logic                      accept;
   logic                      push;
   logic                      pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [AXI_ADDR_WIDTH-1:0] file_addr;
   msi_req_t                  req_in;
   msi_req_t                  head;
   msi_state_e                state_q;
   msi_state_e                state_d;

   assign legal  = (i_msi_eiid != '0)
                && (32'(i_msi_eiid) < NR_SRC)
                && (32'(i_msi_file) < NR_INTP_FILES);
   assign accept = i_msi_valid && o_msi_ready;
   assign push   = accept && legal;

   // Each file owns a 4 KiB page; seteipnum_le sits at offset 0 of the page.
   assign file_addr   = AXI_ADDR_WIDTH'(IMSIC_BASE)
                      + (AXI_ADDR_WIDTH'(i_msi_file) << IMSIC_FILE_SHIFT);
   assign req_in.addr = MSI_ADDR_W'(file_addr);
   assign req_in.data = MSI_DATA_W'(i_msi_eiid);

   msi_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push),
      .wdata (req_in),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (o_pending)
   );

   // Ready comes from registered occupancy only, so a same-cycle pop never reopens a full queue.
   assign o_msi_ready = !fifo_full;
   assign o_wr_ready  = (state_q == ST_ISSUE);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_GUARD;
         // Master raises busy a cycle after the strobe; don't look at it yet.
         ST_GUARD: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!i_wr_busy) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_msi_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         o_msi_err <= accept && !legal;
         if (pop) begin
            o_wr_addr <= AXI_ADDR_WIDTH'(head.addr);
            o_wr_data <= AXI_DATA_WIDTH'(head.data);
         end
      end
   end

endmodule

// File: tb/tb_imsic_msi_issue_queue.sv
// Directed bench for imsic_msi_issue_queue with a scoreboard of expected writes checked on each strobe.
module tb_imsic_msi_issue_queue;

   // Three files so a 2-bit file index exists and file=3 is the out-of-range case.
   localparam int NF = 3;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        busy;
   logic [1:0]  file;
   logic [4:0]  eiid;
   logic        msi_ready;
   logic        wr_ready;
   logic        msi_err;
   logic [63:0] wr_addr;
   logic [63:0] wr_data;
   logic [2:0]  pending;

   int   checks      = 0;
   int   failures    = 0;
   int   cyc         = 0;
   int   strobes     = 0;
   int   last_strobe = -100;
   int   s0;
   exp_t exp_q[$];
   exp_t mon_e;

   imsic_msi_issue_queue #(
      .NR_INTP_FILES (NF)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_msi_valid (valid),
      .o_msi_ready (msi_ready),
      .i_msi_file  (file),
      .i_msi_eiid  (eiid),
      .o_wr_ready  (wr_ready),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .i_wr_busy   (busy),
      .o_msi_err   (msi_err),
      .o_pending   (pending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; offers one request for one cycle and records it if it will be taken.
   task automatic send(input logic [1:0] f, input logic [4:0] e);
      exp_t x;
      valid = 1'b1;
      file  = f;
      eiid  = e;
      if (msi_ready === 1'b1 && e != 0 && e < 30 && f < NF) begin
         x.addr = 64'h2400_0000 + (64'(f) << 12);
         x.data = 64'(e);
         exp_q.push_back(x);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(exp_q.size()), 0);
      repeat (4) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (wr_ready === 1'b1) begin
         strobes++;
         chk("strobe_gap", 64'(cyc - last_strobe >= 3), 1);
         last_strobe = cyc;
         chk("strobe_expected", 64'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_addr", wr_addr, mon_e.addr);
            chk("sb_data", wr_data, mon_e.data);
         end
      end
   end

   initial begin
      rst = 1'b1; valid = 1'b0; busy = 1'b0; file = '0; eiid = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_pending",   pending,   0);
      chk("rst_wr_ready",  wr_ready,  0);
      chk("rst_addr",      wr_addr,   0);
      chk("rst_data",      wr_data,   0);
      chk("rst_err",       msi_err,   0);
      chk("rst_msi_ready", msi_ready, 1);

      // single request: strobe two cycles after acceptance
      send(2'd1, 5'd5);
      chk("t1_n1_ready", wr_ready, 0);
      chk("t1_pending",  pending,  1);
      @(negedge clk);
      chk("t1_n2_ready", wr_ready, 1);
      chk("t1_addr",     wr_addr,  64'h2400_1000);
      chk("t1_data",     wr_data,  5);
      @(negedge clk);
      chk("t1_one_pulse", wr_ready, 0);
      drain("t1_drain");

      // busy hold with two queued behind an in-flight write
      send(2'd0, 5'd7);
      @(negedge clk);
      chk("t2_strobe_a", wr_ready, 1);
      busy = 1'b1;
      send(2'd1, 5'd8);
      send(2'd2, 5'd9);
      for (int i = 0; i < 10; i++) begin
         chk("t2_hold_ready", wr_ready, 0);
         chk("t2_hold_addr",  wr_addr,  64'h2400_0000);
         chk("t2_hold_data",  wr_data,  7);
         @(negedge clk);
      end
      chk("t2_pending", pending, 2);
      busy = 1'b0;
      @(negedge clk);
      chk("t2_strobe_b", wr_ready, 1);
      chk("t2_addr_b",   wr_addr,  64'h2400_1000);
      drain("t2_drain");

      // fill to full while the master is busy
      s0 = strobes;
      send(2'd0, 5'd9);
      @(negedge clk);
      busy = 1'b1;
      for (int i = 1; i <= 4; i++) send(2'd1, 5'(i));
      chk("t3_pending_full", pending,   4);
      chk("t3_ready_low",    msi_ready, 0);
      send(2'd1, 5'd5);
      chk("t3_fifth_refused", pending, 4);
      busy = 1'b0;
      drain("t3_drain");
      chk("t3_strobe_count", 64'(strobes - s0), 5);

      // illegal requests
      s0 = strobes;
      send(2'd0, 5'd0);
      chk("t4_err_eiid0", msi_err, 1);
      @(negedge clk);
      chk("t4_err_drop0", msi_err, 0);
      send(2'd0, 5'd30);
      chk("t4_err_eiid30", msi_err, 1);
      @(negedge clk);
      chk("t4_err_drop30", msi_err, 0);
      send(2'd3, 5'd1);
      chk("t4_err_file", msi_err, 1);
      chk("t4_pending",  pending, 0);
      @(negedge clk);
      chk("t4_err_dropf", msi_err, 0);
      repeat (5) @(negedge clk);
      chk("t4_no_strobe", 64'(strobes - s0), 0);

      // simultaneous push and pop at occupancy 2
      send(2'd0, 5'd11);
      @(negedge clk);
      busy = 1'b1;
      send(2'd0, 5'd12);
      send(2'd0, 5'd13);
      @(negedge clk);
      chk("t5_pending_pre", pending, 2);
      busy = 1'b0;
      send(2'd0, 5'd14);
      chk("t5_pending_same", pending,  2);
      chk("t5_strobe",       wr_ready, 1);
      chk("t5_data",         wr_data,  12);
      drain("t5_drain");

      // reset while waiting with three queued
      send(2'd0, 5'd20);
      @(negedge clk);
      busy = 1'b1;
      send(2'd0, 5'd21);
      send(2'd1, 5'd22);
      send(2'd2, 5'd23);
      @(negedge clk);
      chk("t6_pending_pre", pending, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_pending",   pending,   0);
      chk("t6_wr_ready",  wr_ready,  0);
      chk("t6_msi_ready", msi_ready, 1);
      chk("t6_addr",      wr_addr,   0);
      rst  = 1'b0;
      busy = 1'b0;
      exp_q.delete();
      s0 = strobes;
      repeat (10) @(negedge clk);
      chk("t6_no_strobe", 64'(strobes - s0), 0);
      send(2'd1, 5'd25);
      drain("t6_drain");
      chk("t6_new_strobe", 64'(strobes - s0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
